// File: rtl/addr_capture_pkg.sv
// Shared types and sizing helpers for the serial address capture block.
package addr_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } cap_state_t;

    localparam int WIDTH_DEFAULT = 8;

    // Phase counter must reach 2*width, the value it holds once capture completes.
    function automatic int count_w_for(input int width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/ser_capture_reg.sv
// MSB-first deserialiser for one external shift-register chain.
module ser_capture_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (sample_en) begin
            q <= {q[WIDTH-2:0], serial_in};
        end
    end

endmodule

// File: rtl/serial_address_capture.sv
// Sequencer for two 74HC165-style chains: load strobe, shift clock and word assembly.
module serial_address_capture
    import addr_capture_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int COUNT_W = count_w_for(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 adrin1,
    input  logic                 adrin2,
    output logic                 shld,
    output logic                 serclk,
    output logic [COUNT_W-1:0]   count,
    output logic                 done,
    output logic [2*WIDTH-1:0]   addr
);

    localparam logic [COUNT_W-1:0] LAST_SAMPLE = COUNT_W'(2 * WIDTH - 1);

    cap_state_t       state_reg;
    logic             sample_en;
    logic [1:0]       serial_bits;
    logic [WIDTH-1:0] chain_q [2];

    // Sampling happens on the edge that ends each odd count, while serclk is low
    // and the chain output has had a full clock to settle.
    assign sample_en   = (state_reg == SHIFT) && count[0];
    assign serial_bits = {adrin1, adrin2};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            shld      <= 1'b1;
            serclk    <= 1'b0;
            count     <= '0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg <= LOAD;
                    shld      <= 1'b0;
                    count     <= '0;
                end
                LOAD: begin
                    state_reg <= SHIFT;
                    shld      <= 1'b1;
                    serclk    <= 1'b0;
                    count     <= COUNT_W'(1);
                end
                SHIFT: begin
                    count <= count + COUNT_W'(1);
                    if (count == LAST_SAMPLE) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                        serclk    <= 1'b0;
                        shld      <= 1'b1;
                    end else begin
                        // Next count is even exactly when the current one is odd.
                        serclk <= count[0];
                    end
                end
                DONE: begin
                    state_reg <= DONE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_chain
        ser_capture_reg #(
            .WIDTH(WIDTH)
        ) u_chain (
            .clk      (clk),
            .reset    (reset),
            .sample_en(sample_en),
            .serial_in(serial_bits[gi]),
            .q        (chain_q[gi])
        );
    end

    assign addr = {chain_q[1], chain_q[0]};

endmodule

// File: tb/tb_serial_address_capture.sv
// Directed bench for serial_address_capture with a behavioural pair of 74HC165 chains.
module tb_serial_address_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        adrin1;
    logic        adrin2;
    logic        shld;
    logic        serclk;
    logic [4:0]  count;
    logic        done;
    logic [15:0] addr;

    logic [7:0]  preload1 = 8'h00;
    logic [7:0]  preload2 = 8'h00;
    logic [7:0]  chain1   = 8'h00;
    logic [7:0]  chain2   = 8'h00;
    logic        ovr_en   = 1'b0;
    logic        ovr1     = 1'b0;
    logic        ovr2     = 1'b0;
    int          rises    = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        logic [7:0]  p1;
        logic [7:0]  p2;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    serial_address_capture dut (
        .clk   (clk),
        .reset (reset),
        .adrin1(adrin1),
        .adrin2(adrin2),
        .shld  (shld),
        .serclk(serclk),
        .count (count),
        .done  (done),
        .addr  (addr)
    );

    // '165 model: parallel load while shld low, shift toward QH on serclk rise.
    always @(negedge shld or posedge serclk) begin
        if (!shld) begin
            chain1 <= preload1;
            chain2 <= preload2;
        end else begin
            chain1 <= {chain1[6:0], 1'b0};
            chain2 <= {chain2[6:0], 1'b0};
        end
    end

    always @(posedge serclk) rises++;

    assign adrin1 = ovr_en ? ovr1 : chain1[7];
    assign adrin2 = ovr_en ? ovr2 : chain2[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expects reset currently high; releases it and follows the 17 posedges of a capture.
    task automatic run_capture(input logic [7:0] p1, input logic [7:0] p2,
                               input logic [15:0] exp_addr);
        int errs;
        int rises_start;
        logic       e_shld, e_ser, e_done;
        logic [4:0] e_cnt;
        errs = 0;
        preload1 = p1;
        preload2 = p2;
        @(negedge clk);
        rises_start = rises;
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            e_shld = (k != 1);
            e_cnt  = (k == 1) ? 5'd0 : 5'(k - 1);
            e_done = (k == 17);
            e_ser  = (k >= 3) && (k <= 15) && (((k - 1) % 2) == 0);
            if (shld !== e_shld || count !== e_cnt || done !== e_done || serclk !== e_ser) begin
                errs++;
                if (errs == 1)
                    $display("  cycle %0d: shld=%b count=%0d done=%b serclk=%b (want %b %0d %b %b)",
                             k, shld, count, done, serclk, e_shld, e_cnt, e_done, e_ser);
            end
        end
        check("cycle_seq", errs, 0);
        check("addr", addr, exp_addr);
        check("final_count", count, 16);
        check("done", done, 1);
        check("serclk_rises", rises - rises_start, 7);
        $display("capture %h/%h -> addr=%h count=%0d done=%b rises=%0d",
                 p1, p2, addr, count, done, rises - rises_start);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] held_addr;
        int          errs;
        int          hit;
        int          rises_start;

        vecs[0] = '{p1: 8'hA5, p2: 8'h3C, exp_addr: 16'hA53C};
        vecs[1] = '{p1: 8'hFF, p2: 8'h00, exp_addr: 16'hFF00};
        vecs[2] = '{p1: 8'h00, p2: 8'hFF, exp_addr: 16'h00FF};
        vecs[3] = '{p1: 8'h55, p2: 8'hAA, exp_addr: 16'h55AA};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_shld", shld, 1);
        check("rst_serclk", serclk, 0);
        check("rst_count", count, 0);
        check("rst_done", done, 0);
        check("rst_addr", addr, 0);
        $display("reset state: shld=%b serclk=%b count=%0d done=%b addr=%h",
                 shld, serclk, count, done, addr);

        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            run_capture(vecs[v].p1, vecs[v].p2, vecs[v].exp_addr);
        end

        // DONE must ignore the serial lines indefinitely.
        held_addr = addr;
        errs = 0;
        rises_start = rises;
        ovr_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ovr1 = k[0];
            ovr2 = ~k[1];
            @(posedge clk);
            #1;
            if (addr !== 16'h55AA || count !== 5'd16 || shld !== 1'b1 ||
                serclk !== 1'b0 || done !== 1'b1)
                errs++;
        end
        ovr_en = 1'b0;
        check("done_hold", errs, 0);
        check("done_hold_addr", addr, 16'h55AA);
        check("done_hold_rises", rises - rises_start, 0);
        $display("hold after done: addr=%h (was %h) errs=%0d", addr, held_addr, errs);

        // Asynchronous reset in the middle of shifting.
        @(negedge clk);
        reset = 1'b1;
        preload1 = 8'hC3;
        preload2 = 8'h7E;
        @(negedge clk);
        reset = 1'b0;
        hit = 0;
        for (int i = 0; i < 40 && hit == 0; i++) begin
            @(posedge clk);
            #1;
            if (count == 5'd7) hit = 1;
        end
        check("reach_count7", hit, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_shld", shld, 1);
        check("async_serclk", serclk, 0);
        check("async_count", count, 0);
        check("async_done", done, 0);
        check("async_addr", addr, 0);
        $display("async reset mid-shift: shld=%b serclk=%b count=%0d done=%b addr=%h",
                 shld, serclk, count, done, addr);
        run_capture(8'h12, 8'h34, 16'h1234);

        // Long reset hold keeps everything quiet.
        @(negedge clk);
        reset = 1'b1;
        rises_start = rises;
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (shld !== 1'b1 || serclk !== 1'b0 || done !== 1'b0 || count !== 5'd0)
                errs++;
        end
        check("reset_hold", errs, 0);
        check("reset_hold_rises", rises - rises_start, 0);
        $display("reset hold 10 clks: errs=%0d rises=%0d", errs, rises - rises_start);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
